// File: rtl/ov5642_sccb_write_engine.sv
// Purpose: bit-level SCCB/I2C master that writes one packed word (slave addr + sub-addr + data) to the OV5642.
// Latency: oEND rises 4*CLK_DIV*(2+9*(NUM_BYTE+1)) iCLK cycles after iGO is accepted (9576 at defaults).
// Backpressure: level handshake; iGO is ignored while busy, and oEND holds until iGO drops, so no retrigger.
//
// Ports:
//   iCLK        system clock, all logic on the rising edge
//   iRST        asynchronous active-high reset; abandons any transfer without a STOP
//   iDATA       packed write word, most significant byte goes on the bus first
//   iGO         level request, latched in IDLE only
//   oEND        transfer complete, held until iGO is low
//   oACK        valid with oEND: 0 = all bytes ACKed, 1 = at least one NACK
//   oBUSY       high from acceptance until the transfer reaches DONE
//   oI2C_SCLK   SCL, push-pull
//   ioI2C_SDAT  SDA, open-drain (drives 0 or releases)
module ov5642_sccb_write_engine #(
  parameter int NUM_BYTE = 3,
  parameter int CLK_DIV  = 63
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic [(NUM_BYTE+1)*8-1:0] iDATA,
  input  logic                      iGO,
  output logic                      oEND,
  output logic                      oACK,
  output logic                      oBUSY,
  output logic                      oI2C_SCLK,
  inout  wire                       ioI2C_SDAT
);

  localparam int DW = (NUM_BYTE + 1) * 8;
  localparam int BW = $clog2(NUM_BYTE + 2);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   divCnt;
  logic            tick;
  logic [1:0]      quarter;   // quarter of the current SCL period
  logic [3:0]      bitIdx;    // 0..7 data bits, 8 = ACK slot
  logic [BW-1:0]   byteIdx;   // 0..NUM_BYTE
  logic [DW-1:0]   shiftReg;
  logic            nackFlag;
  logic            sdaLow;    // 1 = pull SDA low, 0 = release
  logic            accept;

  assign tick       = (divCnt == CW'(CLK_DIV - 1));
  assign accept     = (state == IDLE) && iGO && !oEND;
  assign ioI2C_SDAT = sdaLow ? 1'b0 : 1'bz;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      divCnt    <= '0;
      quarter   <= 2'd0;
      bitIdx    <= 4'd0;
      byteIdx   <= '0;
      shiftReg  <= '0;
      nackFlag  <= 1'b0;
      sdaLow    <= 1'b0;
      oI2C_SCLK <= 1'b1;
      oEND      <= 1'b0;
      oACK      <= 1'b0;
      oBUSY     <= 1'b0;
    end else begin
      // Quarter-period divider; restarted on acceptance so every transfer
      // has identical timing relative to the accepting edge.
      if (accept || tick) divCnt <= '0;
      else                divCnt <= divCnt + 1'b1;

      case (state)
        IDLE: begin
          oI2C_SCLK <= 1'b1;
          sdaLow    <= 1'b0;
          if (accept) begin
            shiftReg <= iDATA;
            nackFlag <= 1'b0;
            oBUSY    <= 1'b1;
            quarter  <= 2'd0;
            bitIdx   <= 4'd0;
            byteIdx  <= '0;
            state    <= START;
          end
        end

        // Each case arm below sets the outputs of the quarter being entered.
        START: if (tick) begin
          quarter <= quarter + 2'd1;
          case (quarter)
            2'd0: sdaLow    <= 1'b1;        // SDA falls with SCL high
            2'd2: oI2C_SCLK <= 1'b0;
            2'd3: begin
              state  <= BIT;
              sdaLow <= !shiftReg[DW-1];    // first data bit, SCL already low
            end
            default: ;
          endcase
        end

        BIT: if (tick) begin
          quarter <= quarter + 2'd1;
          case (quarter)
            2'd0: oI2C_SCLK <= 1'b1;
            2'd1: begin
              // Mid-high sample of the slave's acknowledge.
              if (bitIdx == 4'd8 && ioI2C_SDAT == 1'b1) nackFlag <= 1'b1;
            end
            2'd2: begin
              oI2C_SCLK <= 1'b0;
              // Only data slots consume a bit; the ACK slot leaves the next byte at the MSB.
              if (bitIdx != 4'd8) shiftReg <= {shiftReg[DW-2:0], 1'b0};
            end
            default: begin
              if (bitIdx == 4'd8) begin
                bitIdx <= 4'd0;
                if (byteIdx == BW'(NUM_BYTE)) begin
                  state  <= STOP;
                  sdaLow <= 1'b1;           // hold SDA low so it can rise under SCL high
                end else begin
                  byteIdx <= byteIdx + 1'b1;
                  sdaLow  <= !shiftReg[DW-1];
                end
              end else begin
                bitIdx <= bitIdx + 4'd1;
                sdaLow <= (bitIdx == 4'd7) ? 1'b0 : !shiftReg[DW-1];
              end
            end
          endcase
        end

        STOP: if (tick) begin
          quarter <= quarter + 2'd1;
          case (quarter)
            2'd0: oI2C_SCLK <= 1'b1;
            2'd1: sdaLow    <= 1'b0;        // SDA rises with SCL high
            2'd3: begin
              state <= DONE;
              oEND  <= 1'b1;
              oACK  <= nackFlag;
              oBUSY <= 1'b0;
            end
            default: ;
          endcase
        end

        DONE: begin
          // No tick needed; oEND has already been high for at least this cycle.
          if (!iGO) begin
            state <= IDLE;
            oEND  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov5642_sccb_write_engine.sv
// Purpose: self-checking bench for the SCCB write engine with a bus decoder and ACK/NACK slave model.
// Latency: each transfer is expected to finish 9576 cycles after acceptance.
// Backpressure: iGO held, dropped early, or held long after oEND to probe the level handshake.
module tb_ov5642_sccb_write_engine;

  localparam int NUM_BYTE = 3;
  localparam int CLK_DIV  = 63;
  localparam int XFER_CYC = 4 * CLK_DIV * (2 + 9 * (NUM_BYTE + 1));
  localparam int EV_START = -1;
  localparam int EV_STOP  = -2;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [31:0] iDATA = 32'h0;
  logic        iGO = 1'b0;
  logic        oEND, oACK, oBUSY, oI2C_SCLK;
  wire         sda;

  logic        slaveLow = 1'b0;
  logic [3:0]  slaveNack = 4'h0;   // bit b set = slave NACKs byte b (byte 0 = slave address)
  assign sda = slaveLow ? 1'b0 : 1'bz;
  pullup (sda);

  ov5642_sccb_write_engine #(.NUM_BYTE(NUM_BYTE), .CLK_DIV(CLK_DIV)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iGO(iGO),
    .oEND(oEND), .oACK(oACK), .oBUSY(oBUSY),
    .oI2C_SCLK(oI2C_SCLK), .ioI2C_SDAT(sda)
  );

  initial forever #10 iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // Decoded bus activity and the expected activity for the current word.
  int evq[$];
  int expq[$];

  logic prevScl = 1'b1;
  logic prevSda = 1'b1;
  int   riseCnt = 0;

  // Bus decoder plus slave: SDA edges under high SCL are START/STOP,
  // each SCL rise is a sampled bit. The slave pulls SDA low for the ACK
  // slot after the 8th bit of a byte unless told to NACK that byte.
  always @(negedge iCLK) begin
    if (iRST) begin
      slaveLow <= 1'b0;
      riseCnt  <= 0;
    end else begin
      if (prevScl && oI2C_SCLK && prevSda && !sda) begin
        evq.push_back(EV_START);
        riseCnt <= 0;
      end else if (prevScl && oI2C_SCLK && !prevSda && sda) begin
        evq.push_back(EV_STOP);
      end else if (!prevScl && oI2C_SCLK) begin
        evq.push_back(sda ? 1 : 0);
        riseCnt <= riseCnt + 1;
      end else if (prevScl && !oI2C_SCLK && riseCnt > 0) begin
        if (riseCnt % 9 == 8)      slaveLow <= !slaveNack[riseCnt / 9];
        else if (riseCnt % 9 == 0) slaveLow <= 1'b0;
      end
    end
    prevScl <= oI2C_SCLK;
    prevSda <= sda;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: START, 4 bytes MSB first each followed by the slave's ACK
  // bit, then the STOP framing (SCL rises over a low SDA, then SDA rises).
  function automatic void buildExp(input logic [31:0] word, input logic [3:0] nack);
    expq.delete();
    expq.push_back(EV_START);
    for (int b = 0; b < 4; b++) begin
      for (int i = 7; i >= 0; i--) expq.push_back(word[(3 - b) * 8 + i] ? 1 : 0);
      expq.push_back(nack[b] ? 1 : 0);
    end
    expq.push_back(0);
    expq.push_back(EV_STOP);
  endfunction

  task automatic compareBus(input string tag);
    int firstBad;
    int n;
    firstBad = -1;
    n = (evq.size() < expq.size()) ? evq.size() : expq.size();
    for (int i = 0; i < n; i++)
      if (firstBad < 0 && evq[i] != expq[i]) firstBad = i;
    if (firstBad < 0 && evq.size() != expq.size()) firstBad = n;
    chk({tag, " bus_first_bad_event"}, firstBad, -1);
  endtask

  // One complete transfer. dropTick/changeTick > 0 drop iGO / corrupt iDATA
  // that many ticks after acceptance; holdCyc keeps iGO high after oEND.
  task automatic doXfer(input string tag, input logic [31:0] word, input logic [3:0] nack,
                        input int dropTick, input int changeTick, input int holdCyc,
                        input logic expAck);
    int c0, lat, startLat, sz;
    bit flag;
    @(negedge iCLK);
    iDATA = word;
    slaveNack = nack;
    evq.delete();
    buildExp(word, nack);
    iGO = 1'b1;
    c0 = cyc + 1;                     // the edge that accepts iGO
    @(negedge iCLK);
    chk({tag, " busy_after_accept"}, oBUSY, 1);
    startLat = -1;
    lat = cyc - c0;
    while (!oEND && lat < XFER_CYC + 200) begin
      if (startLat < 0 && evq.size() > 0) startLat = lat;
      if (dropTick > 0 && lat == dropTick * CLK_DIV) iGO = 1'b0;
      if (changeTick > 0 && lat == changeTick * CLK_DIV) iDATA = ~word;
      @(negedge iCLK);
      lat = cyc - c0;
    end
    chk({tag, " end_seen"}, oEND, 1);
    chk({tag, " end_latency"}, lat, XFER_CYC);
    chk({tag, " start_within_4q"}, (startLat >= 0 && startLat <= 4 * CLK_DIV) ? 1 : 0, 1);
    chk({tag, " ack"}, oACK, expAck);
    chk({tag, " busy_at_end"}, oBUSY, 0);
    compareBus(tag);
    if (iGO) begin
      sz = evq.size();
      flag = 1'b0;
      for (int i = 0; i < holdCyc; i++) begin
        @(negedge iCLK);
        if (!oEND || oBUSY || evq.size() != sz || !oI2C_SCLK || !sda) flag = 1'b1;
      end
      if (holdCyc > 0) chk({tag, " hold_no_retrigger"}, flag, 0);
      iGO = 1'b0;
    end
    @(negedge iCLK);
    chk({tag, " end_clears_next_cycle"}, oEND, 0);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [3:0]  nack;
    int          dropTick;
    logic        expAck;
  } vec_t;

  initial begin
    vec_t vecs[3];
    logic [31:0] w;
    logic [3:0]  n;
    bit flag;

    vecs[0] = '{word: 32'h78300880, nack: 4'b0000, dropTick: 0,  expAck: 1'b0};
    vecs[1] = '{word: 32'h78300880, nack: 4'b0100, dropTick: 0,  expAck: 1'b1};
    vecs[2] = '{word: 32'hA5C3_3C5A, nack: 4'b1001, dropTick: 40, expAck: 1'b1};

    repeat (3) @(negedge iCLK);
    chk("reset scl", oI2C_SCLK, 1);
    chk("reset sda", sda, 1);
    chk("reset end", oEND, 0);
    chk("reset ack", oACK, 0);
    chk("reset busy", oBUSY, 0);
    iRST = 1'b0;
    repeat (5) @(negedge iCLK);

    for (int i = 0; i < 3; i++)
      doXfer($sformatf("vec%0d", i), vecs[i].word, vecs[i].nack, vecs[i].dropTick, 0, 20,
             vecs[i].expAck);

    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      n = 4'($urandom_range(0, 15));
      doXfer($sformatf("rand%0d", i), w, n, 0, 0, 0, (n != 4'h0));
    end

    // Long hold after oEND, then an immediate new request whose iDATA is
    // corrupted mid-BIT; the bus must carry the latched word.
    doXfer("hold", 32'h42_0A_5F_81, 4'b0000, 0, 0, 500, 1'b0);
    doXfer("dchg", 32'h78_31_03_11, 4'b0010, 0, 30, 0, 1'b1);

    // Asynchronous reset in slot 5 (SCL low, SDA driven low for 0x78 bit 2).
    @(negedge iCLK);
    iDATA = 32'h78300880;
    slaveNack = 4'h0;
    iGO = 1'b1;
    repeat (24 * CLK_DIV + 5) @(negedge iCLK);
    chk("midbit scl_low_before_reset", oI2C_SCLK, 0);
    chk("midbit sda_low_before_reset", sda, 0);
    iGO = 1'b0;
    iRST = 1'b1;
    #1;
    chk("midbit reset scl", oI2C_SCLK, 1);
    chk("midbit reset sda", sda, 1);
    chk("midbit reset busy", oBUSY, 0);
    chk("midbit reset end", oEND, 0);
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge iCLK);
      if (!oI2C_SCLK || !sda || oBUSY || oEND) flag = 1'b1;
    end
    chk("midbit bus_idle_after_reset", flag, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
